// File: rtl/counter_sched_if.sv
// rtl/counter_sched_if.sv - request/grant and counter datapath bundle for counter_sched
interface counter_sched_if #(
   parameter int Width = 8,
   parameter int NREQ  = 4
);
   logic [NREQ-1:0]       req;
   logic [NREQ*Width-1:0] req_data;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       done;
   logic                  busy;
   logic                  dp_load;
   logic [Width-1:0]      dp_din;
   logic                  dp_en;
   logic [Width-1:0]      dp_dout;
   logic [Width-1:0]      job_cnt;

   // Requester logic and counter datapath side
   modport master (
      output req, req_data, dp_dout,
      input  gnt, done, busy, dp_load, dp_din, dp_en, job_cnt
   );

   // Scheduler side
   modport slave (
      input  req, req_data, dp_dout,
      output gnt, done, busy, dp_load, dp_din, dp_en, job_cnt
   );
endinterface

// File: rtl/counter_sched.sv
// rtl/counter_sched.sv - round-robin scheduler sharing one down-counter among NREQ requesters
module counter_sched #(
   parameter int Width = 8,
   parameter int NREQ  = 4
) (
   input  logic           clk_p,
   input  logic           rst_p,
   counter_sched_if.slave bus
);
   localparam int PW = $clog2(NREQ);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t           state;
   state_t           state_n;
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    g_idx;
   logic [PW-1:0]    win_idx;
   logic [PW-1:0]    win_next;
   logic [PW-1:0]    scan_idx;
   logic             win_found;
   logic [Width-1:0] win_data;
   logic [Width-1:0] sv;
   logic [Width-1:0] job_cnt;
   logic [NREQ-1:0]  gnt;
   logic             abort;

   // Round-robin search: first set request at or above ptr, wrapping
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx = PW'((int'(ptr) + k) % NREQ);
         if (!win_found && bus.req[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
      win_data = bus.req_data[int'(win_idx)*Width +: Width];
      win_next = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + PW'(1);
   end

   // The winner withdrawing its request cancels the job in LOAD or RUN
   assign abort = !bus.req[g_idx];

   // Next-state decode; abort takes priority over normal completion
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (win_found) state_n = LOAD;
         LOAD:    state_n = abort ? IDLE : RUN;
         RUN: begin
            if (abort)                    state_n = IDLE;
            else if (bus.dp_dout == '0)   state_n = DONE;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Moore outputs decoded from state; dp_en additionally gated by a nonzero counter
   always_comb begin
      bus.done    = '0;
      bus.busy    = 1'b0;
      bus.dp_load = 1'b0;
      bus.dp_din  = '0;
      bus.dp_en   = 1'b0;
      case (state)
         LOAD: begin
            bus.busy    = 1'b1;
            bus.dp_load = 1'b1;
            bus.dp_din  = sv;
         end
         RUN: begin
            bus.busy  = 1'b1;
            bus.dp_en = (bus.dp_dout != '0);
         end
         DONE: begin
            bus.busy = 1'b1;
            bus.done = gnt;
         end
         default: ;
      endcase
   end

   assign bus.gnt     = gnt;
   assign bus.job_cnt = job_cnt;

   // State register
   always_ff @(posedge clk_p or posedge rst_p) begin
      if (rst_p) state <= IDLE;
      else       state <= state_n;
   end

   // Grant capture, pointer advance and completed-job count
   always_ff @(posedge clk_p or posedge rst_p) begin
      if (rst_p) begin
         ptr     <= '0;
         g_idx   <= '0;
         sv      <= '0;
         gnt     <= '0;
         job_cnt <= '0;
      end else begin
         if (state == IDLE && win_found) begin
            gnt   <= NREQ'(1) << win_idx;
            g_idx <= win_idx;
            sv    <= win_data;
            ptr   <= win_next;
         end else if (state != IDLE && state_n == IDLE) begin
            gnt <= '0;
         end
         if (state == DONE) job_cnt <= job_cnt + Width'(1);
      end
   end
endmodule

// File: tb/tb_counter_sched.sv
// tb/tb_counter_sched.sv - scoreboard bench for counter_sched
module tb_counter_sched;
   localparam int W = 8;
   localparam int N = 4;

   logic clk_p = 1'b0;
   logic rst_p = 1'b1;

   counter_sched_if #(.Width(W), .NREQ(N)) bus ();

   counter_sched #(.Width(W), .NREQ(N)) dut (
      .clk_p(clk_p),
      .rst_p(rst_p),
      .bus  (bus)
   );

   always #5 clk_p = ~clk_p;

   // Shared down-counter datapath
   logic [W-1:0] cnt;
   always_ff @(posedge clk_p or posedge rst_p) begin
      if (rst_p)            cnt <= '0;
      else if (bus.dp_load) cnt <= bus.dp_din;
      else if (bus.dp_en)   cnt <= cnt - W'(1);
   end
   assign bus.dp_dout = cnt;

   typedef struct {
      logic [N-1:0] done;
      int           lat;
      int           en;
   } exp_t;

   exp_t sbq[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input logic [N-1:0] d, input int lat, input int en);
      exp_t e;
      e.done = d;
      e.lat  = lat;
      e.en   = en;
      sbq.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk_p);
      #1;
   endtask

   task automatic set_slice(input int i, input logic [W-1:0] v);
      bus.req_data[i*W +: W] = v;
   endtask

   task automatic wait_done(input int bound, input string name);
      int k = 0;
      while (bus.done == '0 && k < bound) begin
         tick();
         k++;
      end
      check({name, "_timeout"}, 32'(bus.done != '0), 1);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_gnt"},     32'(bus.gnt),     0);
      check({name, "_done"},    32'(bus.done),    0);
      check({name, "_busy"},    32'(bus.busy),    0);
      check({name, "_dp_load"}, 32'(bus.dp_load), 0);
      check({name, "_dp_din"},  32'(bus.dp_din),  0);
      check({name, "_dp_en"},   32'(bus.dp_en),   0);
      check({name, "_job_cnt"}, 32'(bus.job_cnt), 0);
   endtask

   // Reset pulse wholly between two clock edges
   task automatic reset_pulse(input string name);
      rst_p = 1'b1;
      #1;
      check_all_zero(name);
      #1;
      rst_p = 1'b0;
   endtask

   initial begin
      forever begin
         @(posedge clk_p);
         cyc++;
      end
   end

   // Monitor: invariants every cycle, scoreboard pop on each done pulse
   initial begin
      logic [N-1:0] prev_gnt;
      int           gcyc;
      int           en_cnt;
      int           ld_cnt;
      exp_t         e;
      prev_gnt = '0;
      gcyc     = 0;
      en_cnt   = 0;
      ld_cnt   = 0;
      forever begin
         @(negedge clk_p);
         if (rst_p) begin
            prev_gnt = '0;
         end else begin
            check("gnt_onehot", 32'($onehot0(bus.gnt)), 1);
            check("load_en_excl", 32'(bus.dp_load & bus.dp_en), 0);
            if (!bus.dp_load) check("din_idle", 32'(bus.dp_din), 0);
            if (prev_gnt == '0 && bus.gnt != '0) begin
               gcyc   = cyc;
               en_cnt = 0;
               ld_cnt = 0;
            end
            if (bus.dp_en)   en_cnt++;
            if (bus.dp_load) ld_cnt++;
            if (bus.done != '0) begin
               if (sbq.size() == 0) begin
                  check("done_unexpected", 32'(bus.done), 0);
               end else begin
                  e = sbq.pop_front();
                  check("done_vec",    32'(bus.done), 32'(e.done));
                  check("done_gnt",    32'(bus.done), 32'(bus.gnt));
                  check("latency",     32'(cyc - gcyc), 32'(e.lat));
                  check("en_cycles",   32'(en_cnt), 32'(e.en));
                  check("load_cycles", 32'(ld_cnt), 1);
               end
            end
            prev_gnt = bus.gnt;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bus.req      = '0;
      bus.req_data = '0;
      rst_p        = 1'b1;
      repeat (2) tick();
      check_all_zero("por");
      rst_p = 1'b0;
      tick();

      // Single job, requester 0, S=3
      set_slice(0, 8'd3);
      push_exp(4'b0001, 5, 3);
      bus.req = 4'b0001;
      tick();
      check("sj_gnt", 32'(bus.gnt), 32'h1);
      check("sj_busy", 32'(bus.busy), 1);
      wait_done(20, "sj");
      bus.req = '0;
      tick();
      check("sj_job_cnt", 32'(bus.job_cnt), 1);
      check("sj_gnt_clr", 32'(bus.gnt), 0);
      check("sj_busy_clr", 32'(bus.busy), 0);

      // Round robin with all requests held, S=1
      reset_pulse("rst1");
      for (int i = 0; i < N; i++) set_slice(i, 8'd1);
      push_exp(4'b0001, 3, 1);
      push_exp(4'b0010, 3, 1);
      push_exp(4'b0100, 3, 1);
      push_exp(4'b1000, 3, 1);
      push_exp(4'b0001, 3, 1);
      bus.req = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         if (j > 0) tick();
         wait_done(20, "rr");
      end
      bus.req = '0;
      tick();
      check("rr_job_cnt", 32'(bus.job_cnt), 5);

      // Zero start value on requester 2
      set_slice(2, 8'd0);
      push_exp(4'b0100, 2, 0);
      bus.req = 4'b0100;
      wait_done(10, "zs");
      bus.req = '0;
      tick();
      check("zs_job_cnt", 32'(bus.job_cnt), 6);

      // Abort of requester 1 mid-RUN; pending 3 wins over 0
      set_slice(1, 8'd10);
      set_slice(3, 8'd2);
      set_slice(0, 8'd7);
      bus.req = 4'b0010;
      tick();
      check("ab_gnt", 32'(bus.gnt), 32'h2);
      check("ab_load", 32'(bus.dp_load), 1);
      bus.req = 4'b1011;
      repeat (4) tick();
      check("ab_cnt", 32'(bus.dp_dout), 7);
      check("ab_en", 32'(bus.dp_en), 1);
      push_exp(4'b1000, 4, 2);
      bus.req = 4'b1001;
      tick();
      check("ab_busy", 32'(bus.busy), 0);
      check("ab_gnt_clr", 32'(bus.gnt), 0);
      check("ab_done", 32'(bus.done), 0);
      check("ab_job_cnt", 32'(bus.job_cnt), 6);
      tick();
      check("ab_next_gnt", 32'(bus.gnt), 32'h8);
      wait_done(20, "ab3");
      bus.req = '0;
      tick();
      check("ab3_job_cnt", 32'(bus.job_cnt), 7);

      // Asynchronous reset in the middle of RUN
      set_slice(0, 8'd5);
      bus.req = 4'b0001;
      repeat (3) tick();
      check("ar_en", 32'(bus.dp_en), 1);
      reset_pulse("rst2");
      bus.req = 4'b0010;
      set_slice(1, 8'd3);
      push_exp(4'b0010, 5, 3);
      tick();
      check("ar_gnt", 32'(bus.gnt), 32'h2);
      wait_done(20, "ar");
      bus.req = '0;
      tick();
      check("ar_job_cnt", 32'(bus.job_cnt), 1);

      // job_cnt wrap over 256 zero-length jobs
      reset_pulse("rst3");
      set_slice(0, 8'd0);
      for (int j = 0; j < 256; j++) push_exp(4'b0001, 2, 0);
      bus.req = 4'b0001;
      for (int j = 0; j < 255; j++) begin
         if (j > 0) tick();
         wait_done(10, "wr");
      end
      bus.req = '0;
      tick();
      check("wr_job_cnt_255", 32'(bus.job_cnt), 255);
      bus.req = 4'b0001;
      wait_done(10, "wr_last");
      bus.req = '0;
      tick();
      check("wr_job_cnt_0", 32'(bus.job_cnt), 0);

      tick();
      check("sb_empty", 32'(sbq.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
